// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Also provides an elaboration-time helper that checks the digit count.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] ADD3_THRESH = 4'd5;

    // Number of decimal digits needed to show 2^bin_w - 1 (bin_w up to 255).
    function automatic int unsigned min_digits(input int unsigned bin_w);
        logic [255:0] v;
        int unsigned  n;
        v = (256'(1) << bin_w) - 256'(1);
        n = 0;
        while (v != '0) begin
            v = v / 256'(10);
            n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the shift,
// so that it carries correctly into the next digit after doubling.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [DIGIT_W-1:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= ADD3_THRESH) begin
            digit_o = digit_i + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// The bcd output register is only updated when a conversion completes.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin,
    output logic                    busy,
    output logic                    done,
    output logic [DIGIT_W*DIGITS-1:0] bcd
);

    localparam int unsigned SCR_W = DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
        $error("bin2bcd_seq: DIGITS too small to represent 2^BIN_W - 1");
    end

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   sh_q, sh_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCR_W-1:0]   bcd_q, bcd_d;
    logic [SCR_W-1:0]   scratch_adj;
    logic [SCR_W+BIN_W-1:0] shifted;
    logic               accept;
    logic               busy_d, done_d;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (scratch_q[DIGIT_W*i +: DIGIT_W]),
            .digit_o (scratch_adj[DIGIT_W*i +: DIGIT_W])
        );
    end

    // Add-3 acts on pre-shift digits; the whole {scratch, shift} word then doubles.
    assign shifted = {scratch_adj, sh_q} << 1;

    // start is only honoured when not mid-conversion (IDLE or the DONE cycle).
    assign accept = start && (state_q != StShift);

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                busy_d    = 1'b1;
                scratch_d = shifted[SCR_W+BIN_W-1:BIN_W];
                sh_d      = shifted[BIN_W-1:0];
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StDone;
                    bcd_d   = shifted[SCR_W+BIN_W-1:BIN_W];
                end
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = accept ? StShift : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (accept) begin
            sh_d      = bin;
            scratch_d = '0;
            cnt_d     = CNT_W'(BIN_W);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            sh_q      <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
        end
    end

    assign busy = busy_d;
    assign done = done_d;
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: stimulus pushes expected BCD words,
// a negedge monitor pops and compares on every done pulse.
module tb_bin2bcd_seq;

    localparam int unsigned BIN_W  = 16;
    localparam int unsigned DIGITS = 5;

    logic              clk;
    logic              rst;
    logic              start;
    logic [BIN_W-1:0]  bin;
    logic              busy;
    logic              done;
    logic [4*DIGITS-1:0] bcd;

    int errors = 0;
    int checks = 0;
    logic [4*DIGITS-1:0] exp_q[$];
    logic prev_done = 1'b0;

    bin2bcd_seq #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [4*DIGITS-1:0] bcd_ref(input int unsigned v);
        logic [4*DIGITS-1:0] r;
        int unsigned x;
        x = v;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(bcd), 32'hdead);
            end else begin
                check("bcd_result", 32'(bcd), 32'(exp_q.pop_front()));
            end
            for (int i = 0; i < DIGITS; i++) begin
                if (bcd[4*i +: 4] > 4'd9) begin
                    check("digit_range", 32'(bcd[4*i +: 4]), 32'd9);
                end
            end
            if (prev_done) check("done_consecutive", 32'd1, 32'd0);
        end
        prev_done = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_conv(input int unsigned v, input bit expect_done);
        start = 1'b1;
        bin   = BIN_W'(v);
        if (expect_done) exp_q.push_back(bcd_ref(v));
        tick();
        start = 1'b0;
    endtask

    // Returns cycles after accept until done is seen, and busy cycles in between.
    task automatic wait_done(output int n, output int nbusy);
        n = 0;
        nbusy = 0;
        while (!done && n < 40) begin
            if (busy) nbusy++;
            tick();
            n++;
        end
        if (n >= 40) check("done_timeout", 32'(n), 32'd16);
    endtask

    int n, nb, changes;
    logic [4*DIGITS-1:0] held;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (3) tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_bcd", 32'(bcd), 32'd0);
        rst = 1'b0;
        tick();

        // Zero input: latency and busy length.
        start_conv(0, 1'b1);
        wait_done(n, nb);
        check("latency_zero", 32'(n), 32'd16);
        check("busy_cycles_zero", 32'(nb), 32'd16);
        check("busy_in_done", 32'(busy), 32'd0);
        tick();

        start_conv(1234, 1'b1);
        wait_done(n, nb);
        check("bcd_1234", 32'(bcd), 32'h01234);
        tick();

        start_conv(65535, 1'b1);
        wait_done(n, nb);
        check("bcd_65535", 32'(bcd), 32'h65535);
        tick();

        // start while busy is ignored.
        start_conv(42, 1'b1);
        repeat (3) tick();
        start = 1'b1;
        bin   = 16'd999;
        repeat (2) tick();
        start = 1'b0;
        wait_done(n, nb);
        check("latency_ignore", 32'(n + 5), 32'd16);
        check("bcd_42", 32'(bcd), 32'h00042);
        repeat (20) tick();
        check("ignored_not_queued", 32'(exp_q.size()), 32'd0);

        // Previous result held steady throughout the next conversion.
        held = bcd;
        changes = 0;
        start_conv(59999, 1'b1);
        for (int i = 0; i < 16; i++) begin
            if (bcd !== held) changes++;
            tick();
        end
        check("bcd_stable_busy", 32'(changes), 32'd0);
        check("done_after_stable", 32'(done), 32'd1);
        check("bcd_59999", 32'(bcd), 32'h59999);
        tick();

        // Back-to-back: start during the done cycle.
        start_conv(7, 1'b1);
        wait_done(n, nb);
        check("busy_low_in_done", 32'(busy), 32'd0);
        start_conv(50000, 1'b1);
        check("busy_after_b2b", 32'(busy), 32'd1);
        wait_done(n, nb);
        check("latency_b2b", 32'(n + 1), 32'd17);
        check("bcd_50000", 32'(bcd), 32'h50000);
        tick();

        // Reset in cycle 8 discards the in-flight conversion.
        start_conv(12345, 1'b0);
        repeat (7) tick();
        rst = 1'b1;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_bcd", 32'(bcd), 32'd0);
        rst = 1'b0;
        repeat (20) tick();
        start_conv(4321, 1'b1);
        wait_done(n, nb);
        check("latency_after_abort", 32'(n), 32'd16);
        check("bcd_4321", 32'(bcd), 32'h04321);
        tick();

        for (int i = 0; i < 2000; i++) begin
            start_conv($urandom_range(65535, 0), 1'b1);
            wait_done(n, nb);
            tick();
        end

        repeat (3) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
